// File: rtl/systolic_feed_ctrl_if.sv
// Control bundle between a tile sequencer client and systolic_feed_ctrl.
// start/abort come from the client; all other fields are registered DUT outputs.
interface systolic_feed_ctrl_if #(
   parameter int N = 7
);
   // start is a level the controller samples only while idle (no ready return);
   // done is a one-cycle completion pulse, busy covers LOAD through DONE.
   logic         start;
   logic         abort;
   logic         load;
   logic         pe_clear;
   logic [N-1:0] shift;
   logic [N-1:0] valid;
   logic         busy;
   logic         done;
   logic [2:0]   state;

   modport master (
      output start, abort,
      input  load, pe_clear, shift, valid, busy, done, state
   );

   modport slave (
      input  start, abort,
      output load, pe_clear, shift, valid, busy, done, state
   );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sequences load, diagonally skewed shift/valid and drain for one systolic tile.
// Every port is a flop: outputs are decoded from the next state and registered.
module systolic_feed_ctrl #(
   parameter int N         = 7,
   parameter int DEPTH     = 7,
   parameter int DRAIN_CYC = 7
) (
   input logic             clk,
   input logic             reset,
   systolic_feed_ctrl_if.slave bus
);
   localparam int TW = $clog2(N + DEPTH);
   // Keep at least one bit so DRAIN_CYC = 0 still elaborates; the counter is then unused.
   localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(N + DEPTH - 2);
   localparam logic [DW-1:0] D_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   t_q, t_d;
   logic [DW-1:0]   dr_q, dr_d;
   logic            load_q, load_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [N-1:0]    valid_q, valid_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         dr_q    <= '0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         dr_q    <= dr_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      t_d     = '0;
      dr_d    = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = bus.abort ? S_IDLE : S_FEED;
         end
         S_FEED: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (t_q == T_LAST) begin
               state_d = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (dr_q == D_LAST) begin
               state_d = S_DONE;
            end else begin
               dr_d = dr_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Lane i is live while the feed counter sits inside its DEPTH-long window starting at i.
      load_d = (state_d == S_LOAD);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      for (int i = 0; i < N; i++) begin
         valid_d[i] = (state_d == S_FEED) && (int'(t_d) >= i) && (int'(t_d) < i + DEPTH);
      end
   end

   assign bus.load     = load_q;
   assign bus.pe_clear = load_q;
   assign bus.shift    = valid_q;
   assign bus.valid    = valid_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.state    = state_q;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: tile-cycle model with per-cycle compare, attached feeder
// model on the main instance, and directed literal checks including corner parameter sets.
module tb_systolic_feed_ctrl;
   localparam int N   = 7;
   localparam int D   = 7;
   localparam int DC  = 7;
   localparam int LAT = 1 + (N + D - 1) + DC + 1;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   systolic_feed_ctrl_if #(.N(N)) m_if ();
   systolic_feed_ctrl_if #(.N(1)) c1_if ();
   systolic_feed_ctrl_if #(.N(4)) c2_if ();

   systolic_feed_ctrl #(.N(N), .DEPTH(D), .DRAIN_CYC(DC)) dut (
      .clk(clk), .reset(rst_n), .bus(m_if)
   );
   systolic_feed_ctrl #(.N(1), .DEPTH(1), .DRAIN_CYC(0)) dut_c1 (
      .clk(clk), .reset(rst_n), .bus(c1_if)
   );
   systolic_feed_ctrl #(.N(4), .DEPTH(2), .DRAIN_CYC(7)) dut_c2 (
      .clk(clk), .reset(rst_n), .bus(c2_if)
   );

   int checks   = 0;
   int errors   = 0;
   int rel      = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // tile model: m_cyc counts cycles since the tile's start edge, 0 = idle
   int m_cyc = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        m_cyc = 0;
      else if (m_cyc == 0)               m_cyc = m_if.start ? 1 : 0;
      else if (m_if.abort || m_cyc == LAT) m_cyc = 0;
      else                               m_cyc = m_cyc + 1;
   end

   // feeder bank model attached to the main instance: lane i holds {i,1..D-1}
   logic [7:0] fb [N][D];
   int         ptr [N];
   int         lane_cnt [N];
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (m_if.load) begin
            for (int k = 0; k < D; k++) fb[i][k] = (k == 0) ? 8'(i) : 8'(k);
            ptr[i] = 0;
         end else if (m_if.shift[i]) begin
            ptr[i] = ptr[i] + 1;
         end
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin : cmp
      logic [N-1:0] ev;
      logic [7:0]   got_b;
      logic [7:0]   exp_b;
      for (int i = 0; i < N; i++)
         ev[i] = (m_cyc >= 2) && (m_cyc - 2 >= i) && (m_cyc - 2 < i + D);
      chk("m_load",     32'(m_if.load),     32'(m_cyc == 1));
      chk("m_pe_clear", 32'(m_if.pe_clear), 32'(m_cyc == 1));
      chk("m_valid",    32'(m_if.valid),    32'(ev));
      chk("m_shift",    32'(m_if.shift),    32'(ev));
      chk("m_busy",     32'(m_if.busy),     32'(m_cyc != 0));
      chk("m_done",     32'(m_if.done),     32'(m_cyc == LAT));
      if (m_if.done) done_cnt++;
      for (int i = 0; i < N; i++) begin
         if (m_if.load) begin
            lane_cnt[i] = 0;
         end else if (m_if.valid[i]) begin
            got_b = (ptr[i] < D) ? fb[i][ptr[i]] : 8'hEE;
            exp_b = (lane_cnt[i] == 0) ? 8'(i) : 8'(lane_cnt[i]);
            chk("lane_data", 32'(got_b), 32'(exp_b));
            lane_cnt[i] = lane_cnt[i] + 1;
         end
      end
   end

   // driver tasks: inputs change 2 time units after the active edge
   task automatic adv();
      @(posedge clk);
      #2;
      rel++;
   endtask

   task automatic go_to(input int k);
      while (rel < k) adv();
   endtask

   task automatic fire_main();
      adv();
      rel         = 0;
      m_if.start  = 1'b1;
      adv();
      m_if.start  = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : stim
      int d0;
      m_if.start = 1'b0;  m_if.abort = 1'b0;
      c1_if.start = 1'b0; c1_if.abort = 1'b0;
      c2_if.start = 1'b0; c2_if.abort = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;

      chk("rst_load", 32'(m_if.load), 32'd0);
      chk("rst_busy", 32'(m_if.busy), 32'd0);
      chk("rst_shift", 32'(m_if.shift), 32'd0);

      // nominal tile
      d0 = done_cnt;
      fire_main();
      chk("nom_load1", 32'(m_if.load), 32'd1);
      chk("nom_clr1", 32'(m_if.pe_clear), 32'd1);
      go_to(2);  chk("nom_shift2", 32'(m_if.shift), 32'h01);
      go_to(8);  chk("nom_shift8", 32'(m_if.shift), 32'h7F);
      go_to(9);  chk("nom_shift9", 32'(m_if.shift), 32'h7E);
      go_to(14); chk("nom_shift14", 32'(m_if.shift), 32'h40);
      go_to(15); chk("nom_shift15", 32'(m_if.shift), 32'h00);
      chk("nom_busy15", 32'(m_if.busy), 32'd1);
      go_to(21); chk("nom_done21", 32'(m_if.done), 32'd0);
      go_to(22); chk("nom_done22", 32'(m_if.done), 32'd1);
      go_to(23); chk("nom_busy23", 32'(m_if.busy), 32'd0);
      for (int i = 0; i < N; i++) chk("lane_count", 32'(lane_cnt[i]), 32'(D));
      chk("nom_done_pulses", 32'(done_cnt - d0), 32'd1);

      // reset mid-FEED at t = 5
      fire_main();
      go_to(7);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_load", 32'(m_if.load), 32'd0);
      chk("mid_rst_shift", 32'(m_if.shift), 32'd0);
      chk("mid_rst_busy", 32'(m_if.busy), 32'd0);
      chk("mid_rst_done", 32'(m_if.done), 32'd0);
      adv(); adv();
      rst_n = 1'b1;
      repeat (5) adv();
      chk("post_rst_busy", 32'(m_if.busy), 32'd0);
      chk("post_rst_load", 32'(m_if.load), 32'd0);

      // start ignored while busy, then held through DONE
      d0 = done_cnt;
      fire_main();
      go_to(5);  m_if.start = 1'b1;
      adv();     m_if.start = 1'b0;
      go_to(17); m_if.start = 1'b1;
      adv();     m_if.start = 1'b0;
      go_to(21); m_if.start = 1'b1;
      go_to(22); chk("b2b_done22", 32'(m_if.done), 32'd1);
      go_to(23); chk("b2b_load23", 32'(m_if.load), 32'd0);
      chk("b2b_busy23", 32'(m_if.busy), 32'd0);
      chk("b2b_pulses", 32'(done_cnt - d0), 32'd1);
      go_to(24); chk("b2b_load24", 32'(m_if.load), 32'd1);
      m_if.start = 1'b0;
      go_to(24 + LAT);
      chk("b2b_idle", 32'(m_if.busy), 32'd0);

      // abort in DRAIN
      d0 = done_cnt;
      fire_main();
      go_to(17); m_if.abort = 1'b1;
      adv();     m_if.abort = 1'b0;
      chk("abort_busy18", 32'(m_if.busy), 32'd0);
      chk("abort_shift18", 32'(m_if.shift), 32'd0);
      go_to(25);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

      // start and abort together in IDLE, abort kept high into LOAD
      adv();
      rel = 0;
      m_if.start = 1'b1;
      m_if.abort = 1'b1;
      adv();
      m_if.start = 1'b0;
      chk("abl_load1", 32'(m_if.load), 32'd1);
      adv();
      m_if.abort = 1'b0;
      chk("abl_load2", 32'(m_if.load), 32'd0);
      chk("abl_busy2", 32'(m_if.busy), 32'd0);
      go_to(5);
      chk("abl_busy5", 32'(m_if.busy), 32'd0);

      // corner parameter sets
      adv();
      rel = 0;
      c1_if.start = 1'b1;
      c2_if.start = 1'b1;
      adv();
      c1_if.start = 1'b0;
      c2_if.start = 1'b0;
      chk("c1_load1", 32'(c1_if.load), 32'd1);
      chk("c2_load1", 32'(c2_if.load), 32'd1);
      go_to(2);
      chk("c1_shift2", 32'(c1_if.shift), 32'd1);
      chk("c1_done2", 32'(c1_if.done), 32'd0);
      chk("c2_shift2", 32'(c2_if.shift), 32'b0001);
      go_to(3);
      chk("c1_done3", 32'(c1_if.done), 32'd1);
      chk("c1_shift3", 32'(c1_if.shift), 32'd0);
      chk("c2_shift3", 32'(c2_if.shift), 32'b0011);
      go_to(4);
      chk("c1_busy4", 32'(c1_if.busy), 32'd0);
      chk("c2_shift4", 32'(c2_if.shift), 32'b0110);
      go_to(5);  chk("c2_shift5", 32'(c2_if.shift), 32'b1100);
      go_to(6);  chk("c2_shift6", 32'(c2_if.shift), 32'b1000);
      go_to(7);  chk("c2_shift7", 32'(c2_if.shift), 32'b0000);
      chk("c2_busy7", 32'(c2_if.busy), 32'd1);
      go_to(13); chk("c2_done13", 32'(c2_if.done), 32'd0);
      go_to(14); chk("c2_done14", 32'(c2_if.done), 32'd1);
      go_to(15); chk("c2_busy15", 32'(c2_if.busy), 32'd0);

      adv();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
